byte_striping_param: RTL and testbench

//  Parametrised byte striper: distributes a serial stream of WIDTH-bit words round-robin across
//  NUM_LANES parallel lanes (word n -> lane n mod NUM_LANES) and releases each full lane group
//  as one aligned beat. Sits between the link-layer byte source and per-lane encoders.

---
 rtl/byte_striping_param_if.sv | 29 ++
 rtl/byte_striping_param.sv | 148 ++++++++++++++
 tb/tb_byte_striping_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_striping_param_if.sv
// Handshake bundle for byte_striping_param: serial word input side and striped group output side.
// master = upstream source / downstream sink driver, slave = the striper itself.
interface byte_striping_param_if #(
   parameter int NUM_LANES = 4,
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 8
);
   localparam int IDX_W = $clog2(NUM_LANES);

   logic [WIDTH-1:0]           byteStripingIN;
   logic                       byteStripingVLD;
   logic                       byteStripingRDY;
   logic [NUM_LANES*WIDTH-1:0] stripedLanes;
   logic                       stripedVLD;
   logic                       stripedRDY;
   logic [NUM_LANES-1:0]       stripedMASK;
   logic [IDX_W-1:0]           laneIdx;
   logic [CNT_W-1:0]           groupCnt;

   modport master (
      output byteStripingIN, byteStripingVLD, stripedRDY,
      input  byteStripingRDY, stripedLanes, stripedVLD, stripedMASK, laneIdx, groupCnt
   );

   modport slave (
      input  byteStripingIN, byteStripingVLD, stripedRDY,
      output byteStripingRDY, stripedLanes, stripedVLD, stripedMASK, laneIdx, groupCnt
   );
endinterface

// File: rtl/byte_striping_param.sv
// Round-robin byte striper: word n goes to lane n mod NUM_LANES, full groups leave as one beat
// through an accumulator + output double buffer. Optional timed pad flush: STRIPE_FLUSH_PAD_EN.
module byte_striping_param #(
   parameter int          NUM_LANES     = 4,
   parameter int          WIDTH         = 8,
   parameter int          CNT_W         = 8,
   parameter logic [7:0]  PAD_BYTE      = 8'hBC,
   parameter int          FLUSH_TIMEOUT = 4
) (
   input logic                   byteStripingCLK,
   input logic                   byteStripingRSTn,
   byte_striping_param_if.slave  bus
);
   localparam int               IDX_W     = $clog2(NUM_LANES);
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);
   localparam logic [WIDTH-1:0] PAD       = WIDTH'(PAD_BYTE);

   if (NUM_LANES < 2 || FLUSH_TIMEOUT < 1) begin : g_param_check
      $error("byte_striping_param: NUM_LANES must be >= 2 and FLUSH_TIMEOUT >= 1");
   end

   logic [WIDTH-1:0]           acc_p0 [NUM_LANES];
   logic [NUM_LANES*WIDTH-1:0] acc_flat_p0;
   logic [NUM_LANES-1:0]       acc_mask_p0;
   logic                       acc_full;
   logic [IDX_W-1:0]           lane_idx;

   logic [NUM_LANES*WIDTH-1:0] lanes_p1;
   logic [NUM_LANES-1:0]       mask_p1;
   logic                       vld_p1;
   logic [CNT_W-1:0]           group_cnt;

   logic                       rdy;
   logic                       accept;
   logic                       slot_free;
   logic                       last_word;
   logic                       flush;
   logic                       complete;
   logic [NUM_LANES*WIDTH-1:0] grp;
   logic [NUM_LANES-1:0]       grp_mask;

   assign rdy       = byteStripingRSTn & ~acc_full;
   assign accept    = bus.byteStripingVLD & rdy;
   assign slot_free = ~vld_p1 | bus.stripedRDY;
   assign last_word = accept & (lane_idx == LAST_LANE);
   assign complete  = last_word | flush;

`ifdef STRIPE_FLUSH_PAD_EN
   localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_cnt;

   // An accept on the timeout edge wins: the word is taken and no flush happens.
   assign flush = ~accept & (lane_idx != '0) & (idle_cnt == IDLE_W'(FLUSH_TIMEOUT));

   always_ff @(posedge byteStripingCLK or negedge byteStripingRSTn) begin
      if (!byteStripingRSTn) begin
         idle_cnt <= '0;
      end else if (accept || flush) begin
         idle_cnt <= '0;
      end else if (lane_idx != '0) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   // Group as it would leave this edge: incoming word in the last lane, or pad in unfilled lanes.
   always_comb begin
      grp      = '0;
      grp_mask = '1;
      for (int k = 0; k < NUM_LANES; k++) begin
         grp[k*WIDTH +: WIDTH] = acc_p0[k];
         if (flush && (IDX_W'(k) >= lane_idx)) begin
            grp[k*WIDTH +: WIDTH] = PAD;
            grp_mask[k]           = 1'b0;
         end
      end
      if (last_word) begin
         grp[(NUM_LANES-1)*WIDTH +: WIDTH] = bus.byteStripingIN;
      end
   end

   always_comb begin
      acc_flat_p0 = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         acc_flat_p0[k*WIDTH +: WIDTH] = acc_p0[k];
      end
   end

   // p0: accumulator storage (data only, discarded by lane_idx/acc_full reset)
   always_ff @(posedge byteStripingCLK) begin
      if (accept) begin
         acc_p0[lane_idx] <= bus.byteStripingIN;
      end
      if (complete && !slot_free) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            acc_p0[k] <= grp[k*WIDTH +: WIDTH];
         end
      end
   end

   // p1: lane index, parked-group flag and output register
   always_ff @(posedge byteStripingCLK or negedge byteStripingRSTn) begin
      if (!byteStripingRSTn) begin
         lane_idx    <= '0;
         acc_full    <= 1'b0;
         acc_mask_p0 <= '0;
         lanes_p1    <= '0;
         mask_p1     <= '0;
         vld_p1      <= 1'b0;
         group_cnt   <= '0;
      end else begin
         if (accept) begin
            lane_idx <= last_word ? '0 : lane_idx + 1'b1;
         end else if (flush) begin
            lane_idx <= '0;
         end

         if (vld_p1 && bus.stripedRDY) begin
            group_cnt <= group_cnt + 1'b1;
         end

         if (acc_full && slot_free) begin
            lanes_p1 <= acc_flat_p0;
            mask_p1  <= acc_mask_p0;
            vld_p1   <= 1'b1;
            acc_full <= 1'b0;
         end else if (complete && slot_free) begin
            lanes_p1 <= grp;
            mask_p1  <= grp_mask;
            vld_p1   <= 1'b1;
         end else if (complete) begin
            acc_full    <= 1'b1;
            acc_mask_p0 <= grp_mask;
         end else if (vld_p1 && bus.stripedRDY) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.byteStripingRDY = rdy;
   assign bus.stripedLanes    = lanes_p1;
   assign bus.stripedVLD      = vld_p1;
   assign bus.stripedMASK     = mask_p1;
   assign bus.laneIdx         = lane_idx;
   assign bus.groupCnt        = group_cnt;
endmodule

// File: tb/tb_byte_striping_param.sv
// Bench for byte_striping_param (4 lanes x 8 bits): directed scenarios, then a randomized
// stream compared against a word-queue reference model.
module tb_byte_striping_param;
   logic clk;
   logic rst_n;

   byte_striping_param_if #(.NUM_LANES(4), .WIDTH(8), .CNT_W(8)) bus ();

   byte_striping_param #(
      .NUM_LANES(4), .WIDTH(8), .CNT_W(8), .PAD_BYTE(8'hBC), .FLUSH_TIMEOUT(4)
   ) dut (
      .byteStripingCLK (clk),
      .byteStripingRSTn(rst_n),
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         gc_exp = 0;
   logic [7:0] wq[$];
   int         sent, idle_run, cyc;
   logic       v, a, c;
   logic       seen;
   logic [31:0] exp_lanes;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] w);
      bus.byteStripingIN  = w;
      bus.byteStripingVLD = 1'b1;
      tick();
      bus.byteStripingVLD = 1'b0;
   endtask

   // Consume-side reference: a beat leaving now must be the oldest four accepted words.
   task automatic check_beat();
      if (wq.size() < 4) begin
         chk("rand_underflow", 64'(wq.size()), 64'd4);
      end else begin
         exp_lanes = {wq[3], wq[2], wq[1], wq[0]};
         repeat (4) void'(wq.pop_front());
         chk("rand_lanes", 64'(bus.stripedLanes), 64'(exp_lanes));
         chk("rand_mask", 64'(bus.stripedMASK), 64'hF);
      end
      gc_exp++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst_n               = 1'b0;
      bus.byteStripingIN  = '0;
      bus.byteStripingVLD = 1'b0;
      bus.stripedRDY      = 1'b1;
      @(negedge clk);
      tick();
      tick();

      // Scenario 1: reset state
      chk("rst_lanes", 64'(bus.stripedLanes), 64'h0);
      chk("rst_vld", 64'(bus.stripedVLD), 64'h0);
      chk("rst_mask", 64'(bus.stripedMASK), 64'h0);
      chk("rst_lane_idx", 64'(bus.laneIdx), 64'h0);
      chk("rst_group_cnt", 64'(bus.groupCnt), 64'h0);
      chk("rst_rdy", 64'(bus.byteStripingRDY), 64'h0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_rdy", 64'(bus.byteStripingRDY), 64'h1);

      // Scenario 2: one back-to-back group
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("s2_vld", 64'(bus.stripedVLD), 64'h1);
      chk("s2_lanes", 64'(bus.stripedLanes), 64'h44332211);
      chk("s2_mask", 64'(bus.stripedMASK), 64'hF);
      tick();
      gc_exp = 1;
      chk("s2_vld_drop", 64'(bus.stripedVLD), 64'h0);
      chk("s2_lanes_hold", 64'(bus.stripedLanes), 64'h44332211);
      chk("s2_group_cnt", 64'(bus.groupCnt), 64'(gc_exp));

      // Scenario 3: backpressure fills both buffers
      bus.stripedRDY = 1'b0;
      for (int i = 1; i <= 8; i++) send(8'(i));
      chk("s3_rdy_low", 64'(bus.byteStripingRDY), 64'h0);
      chk("s3_first_beat", 64'(bus.stripedLanes), 64'h04030201);
      chk("s3_lane_idx", 64'(bus.laneIdx), 64'h0);
      bus.stripedRDY = 1'b1;
      tick();
      gc_exp++;
      chk("s3_second_beat", 64'(bus.stripedLanes), 64'h08070605);
      chk("s3_second_vld", 64'(bus.stripedVLD), 64'h1);
      chk("s3_rdy_back", 64'(bus.byteStripingRDY), 64'h1);
      tick();
      gc_exp++;
      chk("s3_vld_drop", 64'(bus.stripedVLD), 64'h0);
      chk("s3_group_cnt", 64'(bus.groupCnt), 64'(gc_exp));

      // Scenario 4: gaps in valid keep lane assignment
      send(8'h11); tick(); send(8'h22); tick(); send(8'h33); tick(); send(8'h44);
      chk("s4_vld", 64'(bus.stripedVLD), 64'h1);
      chk("s4_lanes", 64'(bus.stripedLanes), 64'h44332211);
      tick();
      gc_exp++;
      chk("s4_group_cnt", 64'(bus.groupCnt), 64'(gc_exp));

      // Scenario 5: reset mid-group discards partial data
      send(8'hAA); send(8'hBB);
      chk("s5_lane_idx_pre", 64'(bus.laneIdx), 64'h2);
      rst_n = 1'b0;
      #1;
      chk("s5_lane_idx", 64'(bus.laneIdx), 64'h0);
      chk("s5_vld", 64'(bus.stripedVLD), 64'h0);
      chk("s5_group_cnt_clr", 64'(bus.groupCnt), 64'h0);
      tick();
      rst_n  = 1'b1;
      gc_exp = 0;
      tick();
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("s5_lanes", 64'(bus.stripedLanes), 64'h44332211);
      tick();
      gc_exp++;

      // Scenario 6: partial group left idle
      send(8'hA1); send(8'hA2); send(8'hA3);
`ifdef STRIPE_FLUSH_PAD_EN
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         seen = bus.stripedVLD;
      end
      chk("s6_flush_seen", 64'(seen), 64'h1);
      chk("s6_flush_lanes", 64'(bus.stripedLanes), 64'hBCA3A2A1);
      chk("s6_flush_mask", 64'(bus.stripedMASK), 64'h7);
      chk("s6_flush_lane_idx", 64'(bus.laneIdx), 64'h0);
      tick();
      gc_exp++;
`else
      repeat (8) tick();
      chk("s6_hold_vld", 64'(bus.stripedVLD), 64'h0);
      chk("s6_hold_lane_idx", 64'(bus.laneIdx), 64'h3);
      send(8'h44);
      chk("s6_late_lanes", 64'(bus.stripedLanes), 64'h44A3A2A1);
      chk("s6_late_mask", 64'(bus.stripedMASK), 64'hF);
      tick();
      gc_exp++;
`endif
      chk("s6_group_cnt", 64'(bus.groupCnt), 64'(gc_exp));

      // Randomized stream; valid gaps stay short so no partial group ever times out.
      sent = 0; idle_run = 0; cyc = 0;
      while (sent < 200 && cyc < 4000) begin
         v = (idle_run >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         bus.byteStripingVLD = v;
         bus.byteStripingIN  = 8'($urandom);
         bus.stripedRDY      = ($urandom_range(0, 2) != 0);
         #1;
         a = v && bus.byteStripingRDY;
         c = bus.stripedVLD && bus.stripedRDY;
         if (c) check_beat();
         if (a) begin
            wq.push_back(bus.byteStripingIN);
            sent++;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         tick();
         cyc++;
      end
      chk("rand_sent", 64'(sent), 64'd200);
      bus.byteStripingVLD = 1'b0;
      bus.stripedRDY      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.stripedVLD) check_beat();
         tick();
      end
      chk("rand_leftover", 64'(wq.size()), 64'd0);
      chk("rand_vld_idle", 64'(bus.stripedVLD), 64'h0);
      chk("rand_group_cnt", 64'(bus.groupCnt), 64'(gc_exp % 256));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
